// File: rtl/pn_pkg.sv
// Shared types and constants for the PN controller.
package pn_pkg;

    localparam int WEIGHT_W     = 16;
    localparam int WDATA_W      = 32;
    localparam int DRAIN_CYCLES = 2;
    localparam int CNT_W        = 5;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        RUN,
        DRAIN,
        DONE
    } pn_state_e;

endpackage

// File: rtl/pn_rr_arbiter.sv
// Round-robin arbiter: the pointer names the index with first priority and
// moves to the slot after the winner whenever a grant is issued.
module pn_rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_en,
    output logic [N_REQ-1:0] o_gnt
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_nxt;
    logic          w_any;

    // Search from the pointer upward, then wrap to the low indices.
    always_comb begin
        o_gnt     = '0;
        w_ptr_nxt = r_ptr;
        w_any     = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            if (i_en && !w_any && (j >= int'(r_ptr)) && i_req[j]) begin
                o_gnt[j]  = 1'b1;
                w_any     = 1'b1;
                w_ptr_nxt = (j == N_REQ - 1) ? '0 : PW'(j + 1);
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (i_en && !w_any && i_req[j]) begin
                o_gnt[j]  = 1'b1;
                w_any     = 1'b1;
                w_ptr_nxt = (j == N_REQ - 1) ? '0 : PW'(j + 1);
            end
        end
    end

    // Pointer advances only on an actual grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       r_ptr <= '0;
        else if (w_any) r_ptr <= w_ptr_nxt;
    end

endmodule

// File: rtl/pn_controller.sv
// PN controller: loads soma parameters, arbitrates synapse events into the
// soma one per cycle, captures spikes and sequences timestep drains.
module pn_controller
    import pn_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int EV_LIMIT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    input  logic [WDATA_W-1:0]        cfg_data,
    output logic                      cfg_ready,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [WEIGHT_W*N_REQ-1:0] req_weight,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      step,
    input  logic                      halt,
    output logic                      soma_init,
    output logic [WDATA_W-1:0]        soma_w_data,
    output logic                      soma_en,
    output logic [WEIGHT_W-1:0]       soma_weight,
    input  logic [WEIGHT_W-1:0]       soma_spike,
    output logic                      spike_valid,
    output logic [WEIGHT_W-1:0]       spike_data,
    output logic                      step_done,
    output logic                      busy
);

    localparam logic [CNT_W-1:0] EV_LIM    = CNT_W'(EV_LIMIT);
    localparam logic [1:0]       DRAIN_END = 2'(DRAIN_CYCLES - 1);

    pn_state_e             r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_ev_cnt;
    logic [1:0]            r_drain_cnt;
    logic [WDATA_W-1:0]    r_w_data;
    logic                  r_soma_en;
    logic [WEIGHT_W-1:0]   r_soma_weight;
    logic                  r_cap_pend;
    logic                  r_spike_valid;
    logic [WEIGHT_W-1:0]   r_spike_data;

    logic                  w_grant_en;
    logic                  w_cfg_xfer;
    logic [N_REQ-1:0]      w_gnt;
    logic                  w_any_gnt;
    logic [WEIGHT_W-1:0]   w_wt;

    // A step or halt in the same cycle suppresses the grant.
    assign w_grant_en = (r_state == RUN) && !step && !halt && (r_ev_cnt < EV_LIM);
    assign w_cfg_xfer = (r_state == IDLE) && cfg_valid && !halt;
    assign w_any_gnt  = |w_gnt;

    pn_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req (req_valid),
        .i_en  (w_grant_en),
        .o_gnt (w_gnt)
    );

    // Select the weight of the one-hot winner.
    always_comb begin
        w_wt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) w_wt = req_weight[WEIGHT_W*i +: WEIGHT_W];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state and state-decoded outputs; halt overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        cfg_ready   = (r_state == IDLE);
        soma_init   = (r_state == CFG);
        step_done   = (r_state == DONE);
        busy        = (r_state != IDLE);
        if (halt) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (cfg_valid) w_state_nxt = CFG;
                CFG:     w_state_nxt = RUN;
                RUN:     if (step) w_state_nxt = DRAIN;
                DRAIN:   if (r_drain_cnt == DRAIN_END) w_state_nxt = DONE;
                DONE:    w_state_nxt = RUN;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Config word, event counter and drain timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_w_data    <= '0;
            r_ev_cnt    <= '0;
            r_drain_cnt <= '0;
        end else begin
            if (w_cfg_xfer) r_w_data <= cfg_data;
            r_drain_cnt <= (r_state == DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;
            if (r_state == DONE || r_state == IDLE) r_ev_cnt <= '0;
            else if (w_any_gnt)                     r_ev_cnt <= r_ev_cnt + 5'd1;
        end
    end

    // Event pipeline: grant -> soma_en -> spike sample; halt flushes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_soma_en     <= 1'b0;
            r_soma_weight <= '0;
            r_cap_pend    <= 1'b0;
            r_spike_valid <= 1'b0;
            r_spike_data  <= '0;
        end else if (halt) begin
            r_soma_en     <= 1'b0;
            r_cap_pend    <= 1'b0;
            r_spike_valid <= 1'b0;
        end else begin
            r_soma_en     <= w_any_gnt;
            if (w_any_gnt) r_soma_weight <= w_wt;
            r_cap_pend    <= r_soma_en;
            r_spike_valid <= r_cap_pend && (soma_spike != '0);
            if (r_cap_pend && (soma_spike != '0)) r_spike_data <= soma_spike;
        end
    end

    assign req_ready   = w_gnt;
    assign soma_w_data = r_w_data;
    assign soma_en     = r_soma_en;
    assign soma_weight = r_soma_weight;
    assign spike_valid = r_spike_valid;
    assign spike_data  = r_spike_data;

endmodule

// File: doc/pn_controller.md
PN_CONTROLLER -- requirements
Module: pn_controller

Interface
REQ-001 Parameters SHALL be: N_REQ, default 4, number of synapse requesters; EV_LIMIT, default 16, maximum accepted events per timestep.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  configuration word offered.
- cfg_data  in  32  soma parameter word.
- cfg_ready  out  1  configuration word accepted.
- req_valid  in  N_REQ  per-synapse event request.
- req_weight  in  16*N_REQ  per-synapse weight, slice i = [16i+15:16i].
- req_ready  out  N_REQ  one-hot grant.
- step  in  1  timestep boundary pulse.
- halt  in  1  abort to IDLE.
- soma_init  out  1  soma parameter-load strobe, active-high.
- soma_w_data  out  32  soma W_DATA.
- soma_en  out  1  soma integrate enable.
- soma_weight  out  16  weight to soma.
- soma_spike  in  16  soma spike_out.
- spike_valid  out  1  spike event pulse.
- spike_data  out  16  captured spike value.
- step_done  out  1  timestep drained pulse.
- busy  out  1  state is not IDLE.

Function
REQ-003 The FSM SHALL have states IDLE, CFG, RUN, DRAIN and DONE.
REQ-004 In IDLE, cfg_ready SHALL be 1; in every other state it SHALL be 0.
REQ-005 A cfg transfer (cfg_valid and cfg_ready) SHALL register cfg_data into soma_w_data and move to CFG.
REQ-006 CFG SHALL last exactly one cycle with soma_init=1, then move to RUN; soma_w_data SHALL hold until the next cfg transfer.
REQ-007 In RUN with no step and event count below EV_LIMIT, one valid requester per cycle SHALL be granted round-robin, starting at the index after the last granted one; index 0 SHALL have first priority after reset.
REQ-008 req_ready SHALL be combinational from req_valid and state, and SHALL be all-zero outside RUN.
REQ-009 A grant in cycle t SHALL register the granted weight into soma_weight and assert soma_en=1 in cycle t+1 only.
REQ-010 In cycle t+2, a nonzero soma_spike SHALL be captured into spike_data with spike_valid=1 for one cycle; a zero value SHALL produce no pulse.
REQ-011 The 5-bit event counter SHALL increment per grant and saturate at EV_LIMIT; at EV_LIMIT no grant SHALL occur and requests SHALL stay pending.
REQ-012 A step in RUN SHALL win over a same-cycle request (no grant that cycle) and move to DRAIN.
REQ-013 DRAIN SHALL last 2 cycles so in-flight soma_en and spike capture complete, then move to DONE.
REQ-014 DONE SHALL assert step_done=1 for one cycle, clear the event counter and return to RUN.
REQ-015 A step outside RUN SHALL be ignored.
REQ-016 halt SHALL force IDLE on the next edge from any state and drop in-flight soma_en and spike capture.
REQ-017 halt SHALL have priority over step, cfg and requests.

Reset
REQ-018 Reset SHALL set state IDLE, all outputs 0 except cfg_ready=1, round-robin pointer 0, and event counter 0.
REQ-019 Reset asserted mid-operation SHALL abandon the pending grant and spike capture; no spike_valid or step_done SHALL follow reset release.

Structure
REQ-020 Package pn_pkg SHALL hold the FSM state enum, WEIGHT_W=16, WDATA_W=32 and the DRAIN_CYCLES=2 constant.
REQ-021 Sub-module pn_rr_arbiter (N_REQ-wide round-robin, pointer update on grant) SHALL be instantiated once.

Verification
REQ-022 Scenario: cfg_data=0x3C0A0805 with cfg_valid=1 in IDLE -> cfg_ready=1, soma_init=1 next cycle with soma_w_data=0x3C0A0805, then busy=1 in RUN.
REQ-023 Scenario: all 4 req_valid=1 continuously -> grants 0,1,2,3,0; each soma_en follows its grant by exactly 1 cycle with the matching weight.
REQ-024 Scenario: EV_LIMIT=16 and requests held for 20 cycles -> exactly 16 grants, then step -> step_done after 3 cycles and grants resume.
REQ-025 Scenario: soma_spike=0x0012 two cycles after a grant -> spike_valid=1 with spike_data=0x0012; soma_spike=0 -> no pulse.
REQ-026 Scenario: step and req_valid=0001 in the same cycle -> req_ready=0000 and DRAIN entered.
REQ-027 Scenario: halt or rst low one cycle after a grant -> no soma_en and no spike_valid; state IDLE.
